// File: rtl/sobel_frame_ctrl.sv
// Frame controller around the Sobel engine: admits one frame of RX pixels,
// latches the threshold, and buffers engine output toward UART TX.
module sobel_frame_ctrl #(
  parameter int ROW        = 180,
  parameter int COL        = 180,
  parameter int OUT_PIXELS = 31684,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 65535
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic [7:0] thr_cfg,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] pix_data,
  output logic       pix_flag,
  output logic [7:0] thr_out,
  input  logic [7:0] eng_data,
  input  logic       eng_flag,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       err_ovf,
  output logic       err_timeout
);

  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] FRAME_M1 = 16'(ROW * COL - 1);
  localparam logic [15:0] OUT_CNT  = 16'(OUT_PIXELS);
  localparam logic [15:0] TO_M1    = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE, S_ERR} state_e;

  state_e        state_q, state_d;
  logic [7:0]    thr_q, thr_d;
  logic [15:0]   in_cnt_q, in_cnt_d;
  logic [15:0]   out_cnt_q, out_cnt_d;
  logic [15:0]   idle_cnt_q, idle_cnt_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_to_q, err_to_d;
  logic          pix_flag_q, pix_flag_d;
  logic [7:0]    pix_data_q, pix_data_d;

  // Output FIFO: extra pointer bit distinguishes full from empty.
  logic [PW:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          fifo_empty, fifo_full, pop, push, ovf;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign pop        = tx_valid && tx_ready;
  assign push       = eng_flag && (!fifo_full || pop);
  assign ovf        = eng_flag && fifo_full && !pop;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= eng_data;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      thr_q      <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      idle_cnt_q <= '0;
      err_ovf_q  <= 1'b0;
      err_to_q   <= 1'b0;
      pix_flag_q <= 1'b0;
      pix_data_q <= '0;
    end else begin
      state_q    <= state_d;
      thr_q      <= thr_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      err_ovf_q  <= err_ovf_d;
      err_to_q   <= err_to_d;
      pix_flag_q <= pix_flag_d;
      pix_data_q <= pix_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    thr_d      = thr_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    idle_cnt_d = idle_cnt_q;
    err_ovf_d  = err_ovf_q;
    err_to_d   = err_to_q;
    pix_flag_d = 1'b0;
    pix_data_d = pix_data_q;

    if ((state_q == S_LOAD || state_q == S_DRAIN) && eng_flag && out_cnt_q != OUT_CNT)
      out_cnt_d = out_cnt_q + 16'd1;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d    = S_LOAD;
          thr_d      = thr_cfg;
          in_cnt_d   = '0;
          out_cnt_d  = '0;
          idle_cnt_d = '0;
          err_ovf_d  = 1'b0;
          err_to_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (rx_valid) begin
          pix_flag_d = 1'b1;
          pix_data_d = rx_data;
          in_cnt_d   = in_cnt_q + 16'd1;
          if (in_cnt_q == FRAME_M1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Completion is checked first so it wins over a coincident timeout.
        if (out_cnt_q == OUT_CNT && fifo_empty) begin
          state_d = S_DONE;
        end else if (eng_flag) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == TO_M1) begin
          state_d  = S_ERR;
          err_to_d = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (ovf) err_ovf_d = 1'b1;
  end

  assign pix_flag    = pix_flag_q;
  assign pix_data    = pix_data_q;
  assign thr_out     = thr_q;
  assign tx_valid    = !fifo_empty;
  assign tx_data     = tx_valid ? mem_q[rd_ptr_q[PW-1:0]] : '0;
  assign busy        = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign frame_done  = (state_q == S_DONE);
  assign err_ovf     = err_ovf_q;
  assign err_timeout = err_to_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl with a 4x4 frame and a 4-entry FIFO.
module tb_sobel_frame_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] thr_cfg = '0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] pix_data;
  logic       pix_flag;
  logic [7:0] thr_out;
  logic [7:0] eng_data = '0;
  logic       eng_flag = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy, frame_done, err_ovf, err_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] txq[$];

  sobel_frame_ctrl #(.ROW(4), .COL(4), .OUT_PIXELS(4), .FIFO_DEPTH(4), .TIMEOUT(20)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .thr_cfg(thr_cfg),
    .rx_data(rx_data), .rx_valid(rx_valid), .pix_data(pix_data), .pix_flag(pix_flag),
    .thr_out(thr_out), .eng_data(eng_data), .eng_flag(eng_flag), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done),
    .err_ovf(err_ovf), .err_timeout(err_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  // Records every TX beat; sampled mid-cycle, before the popping edge.
  always @(negedge sys_clk) if (tx_valid && tx_ready) txq.push_back(tx_data);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk); #1;
  endtask

  task automatic do_start(input logic [7:0] thr);
    thr_cfg = thr; start = 1'b1; tick; start = 1'b0; thr_cfg = 8'hFF;
    chk("thr_out", thr_out, thr);
    chk("busy_load", busy, 1);
    chk("ovf_clr", err_ovf, 0);
    chk("to_clr", err_timeout, 0);
  endtask

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1; rx_data = base + 8'(i);
      tick;
      rx_valid = 1'b0; rx_data = 8'h00;
      chk("pix_flag", pix_flag, 1);
      chk("pix_data", pix_data, base + 8'(i));
      tick;
      chk("pix_gap", pix_flag, 0);
    end
  endtask

  task automatic eng_pulse(input logic [7:0] d);
    eng_flag = 1'b1; eng_data = d; tick;
    eng_flag = 1'b0; eng_data = 8'h00; tick;
  endtask

  task automatic wait_done;
    int seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (frame_done) seen++;
    end
    chk("frame_done_cnt", seen, 1);
    chk("busy_after", busy, 0);
  endtask

  // Expected beats packed with beat 0 in the low byte.
  task automatic chk_tx(input int n, input logic [39:0] exp);
    chk("tx_beats", txq.size(), n);
    for (int i = 0; i < n; i++) chk($sformatf("tx_beat%0d", i), txq[i], exp[8*i +: 8]);
  endtask

  initial begin
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_pix_flag", pix_flag, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_thr", thr_out, 0);
    sys_rst = 1'b0;
    tick;

    // RX strobes while idle must not reach the engine
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1'b1; rx_data = 8'hE0 + 8'(i); tick;
      rx_valid = 1'b0;
      chk("idle_pix_flag", pix_flag, 0);
      chk("idle_busy", busy, 0);
      tick;
    end

    // Normal frame
    do_start(8'h0C);
    load(16, 8'h10);
    chk("drain_busy", busy, 1);
    chk("thr_hold", thr_out, 8'h0C);
    txq.delete();
    tx_ready = 1'b1;
    eng_pulse(8'hA1); eng_pulse(8'hA2); eng_pulse(8'hA3); eng_pulse(8'hA4);
    wait_done;
    chk_tx(4, {8'h00, 8'hA4, 8'hA3, 8'hA2, 8'hA1});
    chk("thr_after", thr_out, 8'h0C);

    // Back-pressure overflow while idle
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      eng_flag = 1'b1; eng_data = 8'hB1 + 8'(i); tick;
    end
    eng_flag = 1'b0;
    chk("bp_ovf", err_ovf, 1);
    chk("bp_valid", tx_valid, 1);
    chk("bp_head", tx_data, 8'hB1);
    txq.delete();
    tx_ready = 1'b1;
    repeat (8) tick;
    tx_ready = 1'b0;
    chk_tx(4, {8'h00, 8'hB4, 8'hB3, 8'hB2, 8'hB1});
    chk("bp_empty", tx_valid, 0);
    chk("bp_ovf_sticky", err_ovf, 1);

    // Full FIFO with simultaneous push and pop
    do_start(8'h33);
    load(16, 8'h40);
    txq.delete();
    for (int i = 0; i < 4; i++) begin
      eng_flag = 1'b1; eng_data = 8'hC1 + 8'(i); tick;
    end
    eng_flag = 1'b1; eng_data = 8'hC5; tx_ready = 1'b1; tick;
    eng_flag = 1'b0; tx_ready = 1'b0;
    chk("pp_ovf", err_ovf, 0);
    chk("pp_head", tx_data, 8'hC2);
    chk("pp_busy", busy, 1);
    tx_ready = 1'b1;
    wait_done;
    chk_tx(5, {8'hC5, 8'hC4, 8'hC3, 8'hC2, 8'hC1});
    chk("pp_ovf_end", err_ovf, 0);

    // Drain timeout
    do_start(8'h5A);
    load(16, 8'h60);
    txq.delete();
    eng_flag = 1'b1; eng_data = 8'hD1; tick;
    eng_flag = 1'b0; tick;
    eng_flag = 1'b1; eng_data = 8'hD2; tick;
    eng_flag = 1'b0;
    repeat (19) tick;
    chk("to_early", err_timeout, 0);
    chk("to_early_busy", busy, 1);
    tick;
    chk("to_set", err_timeout, 1);
    chk("to_busy", busy, 0);
    chk_tx(2, {24'h0, 8'hD2, 8'hD1});
    tick;
    chk("to_sticky", err_timeout, 1);

    // Restart from the error state, then reset mid-frame
    do_start(8'h21);
    load(6, 8'h80);
    tx_ready = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h86; eng_flag = 1'b1; eng_data = 8'hEE; tick;
    rx_valid = 1'b0; eng_flag = 1'b0;
    chk("pre_rst_pix", pix_flag, 1);
    chk("pre_rst_txv", tx_valid, 1);
    #2 sys_rst = 1'b1;
    #1;
    chk("mrst_pix_flag", pix_flag, 0);
    chk("mrst_pix_data", pix_data, 0);
    chk("mrst_thr", thr_out, 0);
    chk("mrst_tx_valid", tx_valid, 0);
    chk("mrst_tx_data", tx_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", frame_done, 0);
    chk("mrst_ovf", err_ovf, 0);
    chk("mrst_to", err_timeout, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    tick;

    // Full frame after reset; the flushed sample must not reappear
    do_start(8'h77);
    load(16, 8'h90);
    chk("post_rst_busy", busy, 1);
    txq.delete();
    tx_ready = 1'b1;
    eng_pulse(8'hF1); eng_pulse(8'hF2); eng_pulse(8'hF3); eng_pulse(8'hF4);
    wait_done;
    chk_tx(4, {8'h00, 8'hF4, 8'hF3, 8'hF2, 8'hF1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
